// File: rtl/div_pkg.sv
// Shared definitions for the signed divider: the FSM state encoding and the
// default operand width.
package div_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_addsub.sv
// W-bit adder/subtractor used by the divider for both the non-restoring
// iteration step and the final remainder restore.
// Ports:
//   a, b : operands
//   sub  : 1 = a - b (b inverted, carry-in 1), 0 = a + b
//   y    : result (wraps modulo 2^W)
module div_addsub #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);

  assign y = a + (b ^ {W{sub}}) + W'(sub);

endmodule

// File: rtl/signed_divider.sv
// Multi-cycle signed two's-complement divider, truncating toward zero.
// Operand magnitudes are divided with WIDTH non-restoring iterations (one
// quotient bit per cycle), the remainder is restored and signs corrected in
// FIX, and results are published together with a one-cycle done pulse.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begin a division (accepted only while busy=0)
//   dividend, divisor   : signed operands, captured on the accepting edge
//   busy                : operation in progress (through the done cycle)
//   done                : one-cycle pulse, results valid
//   quotient, remainder : signed results, held until the next done
//   div_by_zero         : set with done when the divisor was zero
// Build option: define DIV_ZERO_FASTPATH_EN to finish divide-by-zero
// operations directly from IDLE to DONE, skipping ITER and FIX.
module signed_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   p;        // signed partial remainder
  logic [WIDTH-1:0] q;        // dividend magnitude shifting out, quotient bits in
  logic [WIDTH-1:0] b;        // divisor magnitude
  logic             sign_a;
  logic             sign_b;
  logic             dz;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;

  logic             accept_c;
  logic [WIDTH-1:0] mag_a_c;
  logic [WIDTH-1:0] mag_b_c;
  logic [WIDTH:0]   add_a_c;
  logic [WIDTH:0]   add_b_c;
  logic             add_sub_c;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH-1:0] r_mag_c;

  // Operand magnitudes; -2^(WIDTH-1) negates to itself, read as unsigned 2^(WIDTH-1).
  always_comb begin
    accept_c = start & ~busy;
    mag_a_c  = dividend[WIDTH-1] ? WIDTH'(-dividend) : dividend;
    mag_b_c  = divisor[WIDTH-1]  ? WIDTH'(-divisor)  : divisor;
  end

  // Shared adder: shifted remainder +/- divisor in ITER, remainder + divisor in FIX.
  always_comb begin
    add_b_c = {1'b0, b};
    if (state == FIX) begin
      add_a_c   = p;
      add_sub_c = 1'b0;
    end else begin
      add_a_c   = {p[WIDTH-1:0], q[WIDTH-1]};
      add_sub_c = ~p[WIDTH];
    end
    r_mag_c = p[WIDTH] ? sum_c[WIDTH-1:0] : p[WIDTH-1:0];
  end

  div_addsub #(
    .W (WIDTH + 1)
  ) u_addsub (
    .a   (add_a_c),
    .b   (add_b_c),
    .sub (add_sub_c),
    .y   (sum_c)
  );

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      p           <= '0;
      q           <= '0;
      b           <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      dz          <= 1'b0;
      res_q       <= '0;
      res_r       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (done) begin
            // Closing cycle of an operation; start here is ignored.
            done <= 1'b0;
            busy <= 1'b0;
          end else if (accept_c) begin
            busy   <= 1'b1;
            sign_a <= dividend[WIDTH-1];
            sign_b <= divisor[WIDTH-1];
            dz     <= (divisor == '0);
            p      <= '0;
            q      <= mag_a_c;
            b      <= mag_b_c;
            cnt    <= '0;
`ifdef DIV_ZERO_FASTPATH_EN
            if (divisor == '0) begin
              res_q <= '1;
              res_r <= dividend;
              state <= DONE;
            end else begin
              state <= ITER;
            end
`else
            state <= ITER;
`endif
          end
        end
        ITER: begin
          p   <= sum_c;
          q   <= {q[WIDTH-2:0], ~sum_c[WIDTH]};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          // Zero quotient negates to zero, so its sign follows automatically.
          res_q <= dz ? '1 : ((sign_a ^ sign_b) ? WIDTH'(-q) : q);
          res_r <= sign_a ? WIDTH'(-r_mag_c) : r_mag_c;
          state <= DONE;
        end
        DONE: begin
          quotient    <= res_q;
          remainder   <= res_r;
          div_by_zero <= dz;
          done        <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_divider.sv
// Scoreboard bench for signed_divider: each accepted operation pushes the
// expected result (from integer arithmetic) and the monitor pops on done.
module tb_signed_divider;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int unsigned  lat;
    int unsigned  acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  logic        prev_done = 1'b0;

  signed_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] d);
    exp_t   e;
    longint sa, sd, qq, rr;
    e.acc = 0;
    e.lat = W + 2;
    if (d == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
`ifdef DIV_ZERO_FASTPATH_EN
      e.lat = 1;
`endif
    end else begin
      sa   = longint'($signed(a));
      sd   = longint'($signed(d));
      qq   = sa / sd;
      rr   = sa % sd;
      e.q  = qq[W-1:0];
      e.r  = rr[W-1:0];
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: compare every done against the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 q=%0h", quotient);
      end else begin
        mon_e = sb.pop_front();
        check("quotient", 64'(quotient), 64'(mon_e.q));
        check("remainder", 64'(remainder), 64'(mon_e.r));
        check("div_by_zero", 64'(div_by_zero), 64'(mon_e.dz));
        check("done_latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
        check("busy_with_done", 64'(busy), 64'd1);
      end
    end
    if (prev_done) check("done_single_cycle", 64'(done), 64'd0);
    prev_done = done;
  end

  task automatic wait_not_busy();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("busy_timeout", 64'(busy), 64'd0);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] d, input bit push);
    exp_t e;
    wait_not_busy();
    dividend = a;
    divisor  = d;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    if (push) begin
      e     = model(a, d);
      e.acc = cyc;
      sb.push_back(e);
    end
    check("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [W-1:0] a, d;
    int unsigned  k;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);
    check("rst_dz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;

    issue(32'd100, 32'd7, 1'b1);
    issue(-32'sd100, 32'd7, 1'b1);
    issue(32'd100, -32'sd7, 1'b1);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(32'd5, 32'd0, 1'b1);
    drain();

    // Results hold after done.
    repeat (5) @(negedge clk);
    check("hold_quotient", 64'(quotient), 64'hFFFF_FFFF);
    check("hold_remainder", 64'(remainder), 64'd5);
    check("hold_dz", 64'(div_by_zero), 64'd1);

    // start re-pulsed with new operands mid-ITER is ignored.
    issue(32'd100, 32'd7, 1'b1);
    repeat (5) @(negedge clk);
    dividend = 32'hFFFF_FFFF;
    divisor  = 32'd3;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    drain();

    // Reset at ITER cycle 10 aborts the operation with no later done.
    issue(32'd1234, 32'd5, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_quotient", 64'(quotient), 64'd0);
    check("abort_remainder", 64'(remainder), 64'd0);
    check("abort_dz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_busy", 64'(busy), 64'd0);

    // Randomized operations with corner-value bias.
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      a = $urandom;
      if (k == 0) a = 32'h8000_0000;
      if (k == 1) a = '0;
      k = $urandom_range(0, 9);
      case (k)
        0: d = '0;
        1: d = 32'd1;
        2: d = '1;
        3: d = 32'($urandom_range(1, 20));
        4: d = 32'(-int'($urandom_range(1, 20)));
        5: d = 32'h8000_0000;
        default: d = $urandom;
      endcase
      issue(a, d, 1'b1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
